// File: rtl/vt52_pkg.sv
// Shared VT52 terminal constants: screen geometry, erase fill character,
// erase mode encodings and the erase sequencer state type.
package vt52_pkg;

   localparam int COLS = 64;
   localparam int ROWS = 16;

   localparam logic [7:0] FILL_CHAR = 8'h20;

   localparam logic [1:0] ERASE_EOL  = 2'b00;
   localparam logic [1:0] ERASE_EOS  = 2'b01;
   localparam logic [1:0] ERASE_ALL  = 2'b10;
   localparam logic [1:0] ERASE_LINE = 2'b11;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } erase_state_t;

endpackage

// File: rtl/erase_sequencer.sv
// Single write port of the character buffer, shared between command-handler
// character writes and an erase engine that sweeps fill characters over a span.
module erase_sequencer #(
   parameter int         COL_BITS  = 6,
   parameter int         ROW_BITS  = 4,
   parameter logic [7:0] FILL_CHAR = 8'h20
) (
   input  logic                         clk,
   input  logic                         clr,
   input  logic                         erase_valid,
   output logic                         erase_ready,
   input  logic [1:0]                   erase_mode,
   input  logic [COL_BITS-1:0]          cursor_x,
   input  logic [ROW_BITS-1:0]          cursor_y,
   input  logic [COL_BITS+ROW_BITS-1:0] cmd_addr,
   input  logic [7:0]                   cmd_char,
   input  logic                         cmd_wen,
   output logic                         cmd_ready,
   output logic [COL_BITS+ROW_BITS-1:0] buf_addr,
   output logic [7:0]                   buf_data,
   output logic                         buf_wen,
   output logic                         busy,
   output logic                         erase_done
);
   import vt52_pkg::*;

   localparam int ADDR_BITS = COL_BITS + ROW_BITS;

   // Returns {first, last} addresses of the span to fill for a given mode.
   function automatic logic [2*ADDR_BITS-1:0] span_of(
      input logic [1:0]          mode,
      input logic [COL_BITS-1:0] x,
      input logic [ROW_BITS-1:0] y
   );
      logic [ADDR_BITS-1:0] first;
      logic [ADDR_BITS-1:0] last;
      case (mode)
         ERASE_EOL: begin
            first = {y, x};
            last  = {y, {COL_BITS{1'b1}}};
         end
         ERASE_EOS: begin
            first = {y, x};
            last  = {ADDR_BITS{1'b1}};
         end
         ERASE_ALL: begin
            first = {ADDR_BITS{1'b0}};
            last  = {ADDR_BITS{1'b1}};
         end
         default: begin
            first = {y, {COL_BITS{1'b0}}};
            last  = {y, {COL_BITS{1'b1}}};
         end
      endcase
      return {first, last};
   endfunction

   erase_state_t         r_state;
   erase_state_t         w_state_next;
   logic [ADDR_BITS-1:0] r_ptr;
   logic [ADDR_BITS-1:0] w_ptr_next;
   logic [ADDR_BITS-1:0] r_end;
   logic [ADDR_BITS-1:0] w_end_next;
   logic [ADDR_BITS-1:0] r_buf_addr;
   logic [ADDR_BITS-1:0] w_buf_addr_next;
   logic [7:0]           r_buf_data;
   logic [7:0]           w_buf_data_next;
   logic                 r_buf_wen;
   logic                 w_buf_wen_next;
   logic                 r_erase_done;
   logic                 w_erase_done_next;
   logic [2*ADDR_BITS-1:0] w_span;

   assign w_span = span_of(erase_mode, cursor_x, cursor_y);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state      <= ST_IDLE;
         r_ptr        <= '0;
         r_end        <= '0;
         r_buf_addr   <= '0;
         r_buf_data   <= '0;
         r_buf_wen    <= 1'b0;
         r_erase_done <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_ptr        <= w_ptr_next;
         r_end        <= w_end_next;
         r_buf_addr   <= w_buf_addr_next;
         r_buf_data   <= w_buf_data_next;
         r_buf_wen    <= w_buf_wen_next;
         r_erase_done <= w_erase_done_next;
      end
   end

   // A command write and an erase request may be taken in the same IDLE cycle;
   // the command write lands first, then the sweep overwrites the span.
   always_comb begin
      w_state_next      = r_state;
      w_ptr_next        = r_ptr;
      w_end_next        = r_end;
      w_buf_addr_next   = r_buf_addr;
      w_buf_data_next   = r_buf_data;
      w_buf_wen_next    = 1'b0;
      w_erase_done_next = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (cmd_wen) begin
               w_buf_addr_next = cmd_addr;
               w_buf_data_next = cmd_char;
               w_buf_wen_next  = 1'b1;
            end
            if (erase_valid) begin
               w_ptr_next   = w_span[2*ADDR_BITS-1:ADDR_BITS];
               w_end_next   = w_span[ADDR_BITS-1:0];
               w_state_next = ST_SWEEP;
            end
         end
         default: begin
            w_buf_addr_next = r_ptr;
            w_buf_data_next = FILL_CHAR;
            w_buf_wen_next  = 1'b1;
            w_ptr_next      = r_ptr + 1'b1;
            // Equality with the end address terminates; the pointer never wraps into a write.
            if (r_ptr == r_end) begin
               w_erase_done_next = 1'b1;
               w_state_next      = ST_IDLE;
            end
         end
      endcase
   end

   assign erase_ready = (r_state == ST_IDLE);
   assign cmd_ready   = (r_state == ST_IDLE);
   assign busy        = (r_state == ST_SWEEP);
   assign buf_addr    = r_buf_addr;
   assign buf_data    = r_buf_data;
   assign buf_wen     = r_buf_wen;
   assign erase_done  = r_erase_done;

endmodule

// File: tb/tb_erase_sequencer.sv
// Directed self-checking bench for erase_sequencer: command writes, every
// erase mode shape, write-port arbitration and asynchronous clear mid-sweep.
module tb_erase_sequencer;

   logic       clk;
   logic       clr;
   logic       erase_valid;
   logic       erase_ready;
   logic [1:0] erase_mode;
   logic [5:0] cursor_x;
   logic [3:0] cursor_y;
   logic [9:0] cmd_addr;
   logic [7:0] cmd_char;
   logic       cmd_wen;
   logic       cmd_ready;
   logic [9:0] buf_addr;
   logic [7:0] buf_data;
   logic       buf_wen;
   logic       busy;
   logic       erase_done;

   int checks = 0;
   int passes = 0;

   erase_sequencer #(
      .COL_BITS (6),
      .ROW_BITS (4),
      .FILL_CHAR(8'h20)
   ) dut (
      .clk        (clk),
      .clr        (clr),
      .erase_valid(erase_valid),
      .erase_ready(erase_ready),
      .erase_mode (erase_mode),
      .cursor_x   (cursor_x),
      .cursor_y   (cursor_y),
      .cmd_addr   (cmd_addr),
      .cmd_char   (cmd_char),
      .cmd_wen    (cmd_wen),
      .cmd_ready  (cmd_ready),
      .buf_addr   (buf_addr),
      .buf_data   (buf_data),
      .buf_wen    (buf_wen),
      .busy       (busy),
      .erase_done (erase_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      clr = 1'b1; erase_valid = 1'b0; erase_mode = 2'b00; cursor_x = '0; cursor_y = '0;
      cmd_addr = 10'h155; cmd_char = 8'hAA; cmd_wen = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (buf_addr !== 10'h000 || buf_data !== 8'h00 || buf_wen !== 1'b0 || erase_done !== 1'b0)
         $display("FAIL reset_outputs: addr=%h data=%h wen=%b done=%b, expected 000 00 0 0",
                  buf_addr, buf_data, buf_wen, erase_done);
      else passes++;
      checks++;
      if (busy !== 1'b0 || erase_ready !== 1'b1 || cmd_ready !== 1'b1)
         $display("FAIL reset_state: busy=%b erase_ready=%b cmd_ready=%b, expected 0 1 1",
                  busy, erase_ready, cmd_ready);
      else passes++;
      cmd_wen = 1'b0;
      clr = 1'b0;
      @(negedge clk);
      $display("test_reset complete");
   endtask

   task automatic test_cmd_write();
      cmd_addr = 10'h085; cmd_char = 8'h41; cmd_wen = 1'b1;
      @(negedge clk);
      cmd_wen = 1'b0;
      checks++;
      if (buf_wen !== 1'b1 || buf_addr !== 10'h085 || buf_data !== 8'h41)
         $display("FAIL cmd_write: wen=%b addr=%h data=%h, expected 1 085 41", buf_wen, buf_addr, buf_data);
      else passes++;
      @(negedge clk);
      checks++;
      if (buf_wen !== 1'b0)
         $display("FAIL cmd_write_release: wen=%b, expected 0", buf_wen);
      else passes++;
      $display("test_cmd_write complete");
   endtask

   task automatic test_eol();
      logic [9:0] exp_addr;
      erase_mode = 2'b00; cursor_x = 6'd60; cursor_y = 4'd3; erase_valid = 1'b1;
      @(negedge clk);
      erase_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || erase_ready !== 1'b0 || buf_wen !== 1'b0)
         $display("FAIL eol_accept: busy=%b ready=%b wen=%b, expected 1 0 0", busy, erase_ready, buf_wen);
      else passes++;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         exp_addr = 10'h0FC + 10'(k);
         checks++;
         if (buf_wen !== 1'b1 || buf_addr !== exp_addr || buf_data !== 8'h20)
            $display("FAIL eol_write%0d: wen=%b addr=%h data=%h, expected 1 %h 20",
                     k, buf_wen, buf_addr, buf_data, exp_addr);
         else passes++;
         checks++;
         if (erase_done !== (k == 3))
            $display("FAIL eol_done%0d: done=%b, expected %b", k, erase_done, (k == 3));
         else passes++;
      end
      checks++;
      if (erase_ready !== 1'b1 || busy !== 1'b0)
         $display("FAIL eol_ready: erase_ready=%b busy=%b, expected 1 0", erase_ready, busy);
      else passes++;
      @(negedge clk);
      checks++;
      if (buf_wen !== 1'b0 || erase_done !== 1'b0)
         $display("FAIL eol_after: wen=%b done=%b, expected 0 0", buf_wen, erase_done);
      else passes++;
      $display("test_eol complete");
   endtask

   task automatic test_full_clear();
      int bad = 0;
      int dones = 0;
      int stray = 0;
      logic [9:0] bad_addr = '0;
      logic [9:0] bad_exp = '0;
      erase_mode = 2'b10; cursor_x = 6'd17; cursor_y = 4'd9; erase_valid = 1'b1;
      @(negedge clk);
      erase_valid = 1'b0;
      for (int k = 0; k < 1024; k++) begin
         @(negedge clk);
         if (buf_wen !== 1'b1 || buf_addr !== 10'(k) || buf_data !== 8'h20) begin
            if (bad == 0) begin
               bad_addr = buf_addr;
               bad_exp  = 10'(k);
            end
            bad++;
         end
         if (erase_done === 1'b1) begin
            dones++;
            if (k != 1023) bad++;
         end
      end
      checks++;
      if (bad != 0)
         $display("FAIL full_sequence: %0d bad cycles, first addr=%h expected %h", bad, bad_addr, bad_exp);
      else passes++;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (buf_wen !== 1'b0) stray++;
         if (erase_done === 1'b1) dones++;
      end
      checks++;
      if (stray != 0)
         $display("FAIL full_no_wrap: %0d writes after 3FF (last addr=%h), expected 0", stray, buf_addr);
      else passes++;
      checks++;
      if (dones != 1)
         $display("FAIL full_done_count: %0d pulses, expected 1", dones);
      else passes++;
      $display("test_full_clear complete");
   endtask

   task automatic test_simultaneous();
      int bad = 0;
      logic [9:0] exp_addr;
      cmd_addr = 10'h3C0; cmd_char = 8'h5A; cmd_wen = 1'b1;
      erase_mode = 2'b01; cursor_x = 6'd0; cursor_y = 4'd15; erase_valid = 1'b1;
      @(negedge clk);
      cmd_wen = 1'b0; erase_valid = 1'b0;
      checks++;
      if (buf_wen !== 1'b1 || buf_addr !== 10'h3C0 || buf_data !== 8'h5A || busy !== 1'b1)
         $display("FAIL simul_cmd_first: wen=%b addr=%h data=%h busy=%b, expected 1 3c0 5a 1",
                  buf_wen, buf_addr, buf_data, busy);
      else passes++;
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         exp_addr = 10'h3C0 + 10'(k);
         if (buf_wen !== 1'b1 || buf_addr !== exp_addr || buf_data !== 8'h20 || erase_done !== (k == 63))
            bad++;
      end
      checks++;
      if (bad != 0)
         $display("FAIL simul_sweep: %0d bad cycles (final addr=%h), expected 0", bad, buf_addr);
      else passes++;
      @(negedge clk);
      checks++;
      if (buf_wen !== 1'b0 || erase_ready !== 1'b1)
         $display("FAIL simul_end: wen=%b ready=%b, expected 0 1", buf_wen, erase_ready);
      else passes++;
      $display("test_simultaneous complete");
   endtask

   task automatic test_cmd_during_sweep();
      int low_cycles = 0;
      int bad = 0;
      logic [9:0] exp_addr;
      erase_mode = 2'b11; cursor_x = 6'd33; cursor_y = 4'd5; erase_valid = 1'b1;
      @(negedge clk);
      erase_valid = 1'b0;
      cmd_addr = 10'h123; cmd_char = 8'h77; cmd_wen = 1'b1;
      if (cmd_ready === 1'b0) low_cycles++;
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         exp_addr = 10'h140 + 10'(k);
         if (buf_wen !== 1'b1 || buf_addr !== exp_addr || buf_data !== 8'h20) bad++;
         if (cmd_ready === 1'b0) low_cycles++;
      end
      checks++;
      if (bad != 0)
         $display("FAIL line_sweep: %0d bad cycles (final addr=%h data=%h), expected 0", bad, buf_addr, buf_data);
      else passes++;
      checks++;
      if (low_cycles != 64)
         $display("FAIL line_cmd_ready_low: %0d cycles, expected 64", low_cycles);
      else passes++;
      @(negedge clk);
      cmd_wen = 1'b0;
      checks++;
      if (buf_wen !== 1'b1 || buf_addr !== 10'h123 || buf_data !== 8'h77)
         $display("FAIL line_held_cmd: wen=%b addr=%h data=%h, expected 1 123 77", buf_wen, buf_addr, buf_data);
      else passes++;
      @(negedge clk);
      checks++;
      if (buf_wen !== 1'b0)
         $display("FAIL line_no_duplicate: wen=%b, expected 0", buf_wen);
      else passes++;
      $display("test_cmd_during_sweep complete");
   endtask

   task automatic test_clr_mid_sweep();
      int bad = 0;
      int stray = 0;
      erase_mode = 2'b10; cursor_x = '0; cursor_y = '0; erase_valid = 1'b1;
      @(negedge clk);
      erase_valid = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (buf_wen !== 1'b1 || buf_addr !== 10'(k)) bad++;
      end
      checks++;
      if (bad != 0)
         $display("FAIL clr_pre_writes: %0d bad cycles, expected 0", bad);
      else passes++;
      #2 clr = 1'b1;
      #1;
      checks++;
      if (buf_wen !== 1'b0 || busy !== 1'b0 || erase_done !== 1'b0)
         $display("FAIL clr_async_drop: wen=%b busy=%b done=%b, expected 0 0 0", buf_wen, busy, erase_done);
      else passes++;
      @(negedge clk);
      clr = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (buf_wen !== 1'b0 || erase_done !== 1'b0) stray++;
      end
      checks++;
      if (stray != 0)
         $display("FAIL clr_no_resume: %0d cycles with wen/done, expected 0", stray);
      else passes++;
      checks++;
      if (erase_ready !== 1'b1 || busy !== 1'b0 || buf_addr !== 10'h000)
         $display("FAIL clr_idle: ready=%b busy=%b addr=%h, expected 1 0 000", erase_ready, busy, buf_addr);
      else passes++;
      $display("test_clr_mid_sweep complete");
   endtask

   initial begin
      test_reset();
      test_cmd_write();
      test_eol();
      test_full_clear();
      test_simultaneous();
      test_cmd_during_sweep();
      test_clr_mid_sweep();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
